// File: rtl/cdc_clear_sync_pkg.sv
// Shared types for the clear domain: the clear sequencer phase encoding,
// the channel-count ceiling and a helper that tells whether a phase isolates.
package cdc_clear_sync_pkg;

    typedef enum logic [1:0] {
        CLEAR_SEQ_IDLE       = 2'd0,
        CLEAR_SEQ_ISOLATE    = 2'd1,
        CLEAR_SEQ_CLEAR      = 2'd2,
        CLEAR_SEQ_POST_CLEAR = 2'd3
    } clear_seq_phase_e;

    localparam int unsigned ClearSeqMaxChannels = 32;

    // Isolation is held through every phase except IDLE.
    function automatic logic clear_seq_is_isolated(clear_seq_phase_e phase);
        return phase != CLEAR_SEQ_IDLE;
    endfunction

endpackage

// File: rtl/clear_seq_ctrl.sv
// Clear sequencer: walks the enabled channels through
// IDLE -> ISOLATE -> CLEAR -> POST_CLEAR -> IDLE. Each phase waits for an
// acknowledge from every enabled channel, honours a minimum hold time and,
// when configured, gives up after a timeout while recording the silent
// channels. One request arriving mid-sequence is queued.
//
//   state       | meaning
//   ------------+------------------------------------------------------
//   IDLE        | no sequence running; accepts a new or queued request
//   ISOLATE     | isolation asserted, agents quiescing
//   CLEAR       | isolation and clear strobe asserted
//   POST_CLEAR  | clear released, isolation held while agents recover
module clear_seq_ctrl
    import cdc_clear_sync_pkg::*;
#(
    parameter int unsigned NumChannels   = 4,
    parameter int unsigned MinHoldCycles = 2,
    parameter int unsigned TimeoutCycles = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_req_i,
    input  logic [NumChannels-1:0] chan_en_i,
    input  logic [NumChannels-1:0] ack_i,
    input  logic                   err_clr_i,
    output logic [1:0]             phase_o,
    output logic                   isolate_o,
    output logic                   clear_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [NumChannels-1:0] err_chan_o
);

    localparam int unsigned CntMax      = (MinHoldCycles > TimeoutCycles) ? MinHoldCycles
                                                                          : TimeoutCycles;
    localparam int unsigned CntW        = $clog2(CntMax + 1);
    localparam int unsigned TimeoutLast = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;

    localparam logic [CntW-1:0] HoldLastV    = CntW'(MinHoldCycles - 1);
    localparam logic [CntW-1:0] TimeoutLastV = CntW'(TimeoutLast);
    localparam logic [CntW-1:0] CntMaxV      = CntW'(CntMax);

    if (MinHoldCycles < 1) begin : gen_bad_min_hold
        $error("clear_seq_ctrl: MinHoldCycles must be at least 1");
    end
    if (TimeoutCycles != 0 && TimeoutCycles <= MinHoldCycles) begin : gen_bad_timeout
        $error("clear_seq_ctrl: TimeoutCycles must be 0 or exceed MinHoldCycles");
    end
    if (NumChannels < 1 || NumChannels > ClearSeqMaxChannels) begin : gen_bad_channels
        $error("clear_seq_ctrl: NumChannels must be within 1..ClearSeqMaxChannels");
    end

    clear_seq_phase_e       phase_q;
    clear_seq_phase_e       phase_next;
    logic [NumChannels-1:0] mask_q;
    logic [NumChannels-1:0] ack_seen_q;
    logic [CntW-1:0]        cnt_q;
    logic                   pending_q;
    logic                   done_q;
    logic                   err_q;
    logic [NumChannels-1:0] err_chan_q;
    logic                   isolate_q;
    logic                   clear_q;

    logic in_seq;
    logic all_acked;
    logic timeout_hit;
    logic advance;

    // Phase advance decision; current-cycle acks already count as received.
    always_comb begin
        in_seq      = (phase_q != CLEAR_SEQ_IDLE);
        all_acked   = &(ack_seen_q | ack_i | ~mask_q);
        timeout_hit = in_seq && (TimeoutCycles != 0) && (cnt_q == TimeoutLastV) && !all_acked;
        advance     = in_seq && (((cnt_q >= HoldLastV) && all_acked) || timeout_hit);
        phase_next  = CLEAR_SEQ_IDLE;
        case (phase_q)
            CLEAR_SEQ_ISOLATE:    phase_next = CLEAR_SEQ_CLEAR;
            CLEAR_SEQ_CLEAR:      phase_next = CLEAR_SEQ_POST_CLEAR;
            CLEAR_SEQ_POST_CLEAR: phase_next = CLEAR_SEQ_IDLE;
            default:              phase_next = CLEAR_SEQ_ISOLATE;
        endcase
    end

    // Sequencer state, hold/timeout counter, request queue and sticky error capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q    <= CLEAR_SEQ_IDLE;
            mask_q     <= '0;
            ack_seen_q <= '0;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_chan_q <= '0;
            isolate_q  <= 1'b0;
            clear_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (timeout_hit) begin
                err_q      <= 1'b1;
                err_chan_q <= err_chan_q | (mask_q & ~(ack_seen_q | ack_i));
            end else if (err_clr_i) begin
                err_q      <= 1'b0;
                err_chan_q <= '0;
            end

            if (!in_seq) begin
                if (clear_req_i || pending_q) begin
                    phase_q   <= CLEAR_SEQ_ISOLATE;
                    isolate_q <= 1'b1;
                    clear_q   <= 1'b0;
                    mask_q    <= chan_en_i;
                    pending_q <= 1'b0;
                end
            end else begin
                if (clear_req_i) begin
                    pending_q <= 1'b1;
                end
                if (advance) begin
                    phase_q    <= phase_next;
                    isolate_q  <= clear_seq_is_isolated(phase_next);
                    clear_q    <= (phase_next == CLEAR_SEQ_CLEAR);
                    cnt_q      <= '0;
                    ack_seen_q <= '0;
                    if (phase_q == CLEAR_SEQ_POST_CLEAR) begin
                        done_q <= 1'b1;
                    end
                end else begin
                    if (cnt_q != CntMaxV) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    ack_seen_q <= ack_seen_q | (ack_i & mask_q);
                end
            end
        end
    end

    assign phase_o    = phase_q;
    assign isolate_o  = isolate_q;
    assign clear_o    = clear_q;
    assign busy_o     = in_seq | pending_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_chan_o = err_chan_q;

endmodule

// File: tb/tb_clear_seq_ctrl.sv
// Directed bench for clear_seq_ctrl. Three instances share the stimulus:
// dut_a (MinHold 2, no timeout), dut_t (MinHold 2, timeout 8) and
// dut_m (MinHold 3, no timeout). Each task resets all three and checks one.
module tb_clear_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [3:0] chan_en = '0;
    logic [3:0] ack = '0;
    logic       err_clr = 1'b0;

    logic [1:0] a_phase, t_phase, m_phase;
    logic       a_iso, a_clr, a_busy, a_done, a_err;
    logic       t_iso, t_clr, t_busy, t_done, t_err;
    logic       m_iso, m_clr, m_busy, m_done, m_err;
    logic [3:0] a_echan, t_echan, m_echan;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    clear_seq_ctrl #(.NumChannels(4), .MinHoldCycles(2), .TimeoutCycles(0)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .clear_req_i(req), .chan_en_i(chan_en), .ack_i(ack),
        .err_clr_i(err_clr), .phase_o(a_phase), .isolate_o(a_iso), .clear_o(a_clr),
        .busy_o(a_busy), .done_o(a_done), .err_o(a_err), .err_chan_o(a_echan));

    clear_seq_ctrl #(.NumChannels(4), .MinHoldCycles(2), .TimeoutCycles(8)) dut_t (
        .clk_i(clk), .rst_ni(rst_n), .clear_req_i(req), .chan_en_i(chan_en), .ack_i(ack),
        .err_clr_i(err_clr), .phase_o(t_phase), .isolate_o(t_iso), .clear_o(t_clr),
        .busy_o(t_busy), .done_o(t_done), .err_o(t_err), .err_chan_o(t_echan));

    clear_seq_ctrl #(.NumChannels(4), .MinHoldCycles(3), .TimeoutCycles(0)) dut_m (
        .clk_i(clk), .rst_ni(rst_n), .clear_req_i(req), .chan_en_i(chan_en), .ack_i(ack),
        .err_clr_i(err_clr), .phase_o(m_phase), .isolate_o(m_iso), .clear_o(m_clr),
        .busy_o(m_busy), .done_o(m_done), .err_o(m_err), .err_chan_o(m_echan));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req     = 1'b0;
        chan_en = '0;
        ack     = '0;
        err_clr = 1'b0;
        rst_n   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [9:0] va, vt, vm;
        req = 1'b0; chan_en = '0; ack = '0; err_clr = 1'b0; rst_n = 1'b0;
        tick();
        va = {a_phase, a_iso, a_clr, a_busy, a_done, a_err, a_echan};
        vt = {t_phase, t_iso, t_clr, t_busy, t_done, t_err, t_echan};
        vm = {m_phase, m_iso, m_clr, m_busy, m_done, m_err, m_echan};
        total += 3;
        if (va !== 10'b0) begin bad++; $display("FAIL reset_a got=%b exp=0", va); end
        if (vt !== 10'b0) begin bad++; $display("FAIL reset_t got=%b exp=0", vt); end
        if (vm !== 10'b0) begin bad++; $display("FAIL reset_m got=%b exp=0", vm); end
        rst_n = 1'b1;
        tick();
        va = {a_phase, a_iso, a_clr, a_busy, a_done, a_err, a_echan};
        total++;
        if (va !== 10'b0) begin bad++; $display("FAIL reset_release got=%b exp=0", va); end
    endtask

    // All acks held high: 2 cycles per phase, done on cycle 7.
    task automatic test_basic();
        int ph [1:9] = '{1, 1, 2, 2, 3, 3, 0, 0, 0};
        logic [1:0] e;
        do_reset();
        chan_en = 4'hF; ack = 4'hF; req = 1'b1;
        tick();
        req = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            e = 2'(ph[k]);
            total++;
            if ({a_phase, a_iso, a_clr, a_done, a_busy} !== {e, e != 0, e == 2, k == 7, e != 0}) begin
                bad++;
                $display("FAIL basic k=%0d got ph=%0d iso=%b clr=%b done=%b busy=%b exp ph=%0d done=%b",
                         k, a_phase, a_iso, a_clr, a_done, a_busy, e, k == 7);
            end
            tick();
        end
        total++;
        if (a_err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", a_err); end
    endtask

    // Ch2 acks only at entry+5; an earlier IDLE ack from ch2 must not count.
    task automatic test_late_ack();
        int ph [1:12] = '{1, 1, 1, 1, 1, 1, 2, 2, 3, 3, 0, 0};
        logic [1:0] e;
        do_reset();
        chan_en = 4'hF; ack = 4'hF;
        tick();
        ack = 4'b1011; req = 1'b1;
        tick();
        req = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            e = 2'(ph[k]);
            total++;
            if ({a_phase, a_done} !== {e, k == 11}) begin
                bad++;
                $display("FAIL late_ack k=%0d got ph=%0d done=%b exp ph=%0d done=%b",
                         k, a_phase, a_done, e, k == 11);
            end
            if (k >= 6) ack = 4'hF;
            tick();
        end
    endtask

    // Masked-out silent channel does not stall the sequence.
    task automatic test_mask();
        int ph [1:8] = '{1, 1, 2, 2, 3, 3, 0, 0};
        logic [1:0] e;
        do_reset();
        chan_en = 4'b1011; ack = 4'b1011; req = 1'b1;
        tick();
        req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            e = 2'(ph[k]);
            total++;
            if ({a_phase, a_done} !== {e, k == 7}) begin
                bad++;
                $display("FAIL mask k=%0d got ph=%0d done=%b exp ph=%0d done=%b",
                         k, a_phase, a_done, e, k == 7);
            end
            tick();
        end
        total++;
        if ({a_err, a_echan} !== 5'b0) begin
            bad++; $display("FAIL mask_err got=%b exp=0", {a_err, a_echan});
        end
    endtask

    // Ch3 enabled but silent with timeout 8: every phase lasts 8 cycles.
    task automatic test_timeout();
        logic [1:0] e;
        logic       ee;
        do_reset();
        chan_en = 4'b1011; ack = 4'b0011; req = 1'b1;
        tick();
        req = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            e  = (k <= 8) ? 2'd1 : (k <= 16) ? 2'd2 : (k <= 24) ? 2'd3 : 2'd0;
            ee = (k >= 9);
            total++;
            if ({t_phase, t_done, t_err, t_echan} !== {e, k == 25, ee, ee ? 4'b1000 : 4'b0000}) begin
                bad++;
                $display("FAIL timeout k=%0d got ph=%0d done=%b err=%b echan=%b exp ph=%0d err=%b",
                         k, t_phase, t_done, t_err, t_echan, e, ee);
            end
            tick();
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++;
        if ({t_err, t_echan} !== 5'b0) begin
            bad++; $display("FAIL err_clr got err=%b echan=%b exp 0", t_err, t_echan);
        end
        tick();
        total++;
        if ({t_err, t_echan, t_phase} !== 7'b0) begin
            bad++; $display("FAIL err_clr_hold got=%b exp 0", {t_err, t_echan, t_phase});
        end
    endtask

    // Two requests during CLEAR merge into one queued sequence.
    task automatic test_back_to_back();
        int ph [1:16] = '{1, 1, 2, 2, 3, 3, 0, 1, 1, 2, 2, 3, 3, 0, 0, 0};
        logic [1:0] e;
        int dones = 0;
        do_reset();
        chan_en = 4'hF; ack = 4'hF; req = 1'b1;
        tick();
        req = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            e = 2'(ph[k]);
            total++;
            if ({a_phase, a_done, a_busy} !== {e, (k == 7) || (k == 14), (e != 0) || (k == 7)}) begin
                bad++;
                $display("FAIL b2b k=%0d got ph=%0d done=%b busy=%b exp ph=%0d", k, a_phase, a_done, a_busy, e);
            end
            if (a_done === 1'b1) dones++;
            req = (k == 3) || (k == 4);
            tick();
        end
        req = 1'b0;
        total++;
        if (dones != 2) begin bad++; $display("FAIL b2b_done_count got=%0d exp=2", dones); end
    endtask

    // Reset mid-CLEAR aborts at once and discards the queued request.
    task automatic test_reset_abort();
        int dones = 0;
        do_reset();
        chan_en = 4'hF; ack = 4'hF; req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        tick();
        total++;
        if ({a_phase, a_clr, a_iso} !== {2'd2, 1'b1, 1'b1}) begin
            bad++; $display("FAIL abort_pre got ph=%0d clr=%b iso=%b exp ph=2", a_phase, a_clr, a_iso);
        end
        req = 1'b1;
        tick();
        req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({a_phase, a_iso, a_clr, a_busy, a_done} !== 6'b0) begin
            bad++;
            $display("FAIL abort_now got ph=%0d iso=%b clr=%b busy=%b done=%b exp 0",
                     a_phase, a_iso, a_clr, a_busy, a_done);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (a_done !== 1'b0 || a_phase !== 2'd0) dones++;
        end
        total++;
        if (dones != 0) begin bad++; $display("FAIL abort_after got=%0d active cycles exp=0", dones); end
    endtask

    // Empty mask: MinHold=3 sets every phase length regardless of acks.
    task automatic test_zero_mask();
        int ph [1:11] = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0};
        logic [1:0] e;
        do_reset();
        chan_en = 4'h0; req = 1'b1;
        tick();
        req = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            e = 2'(ph[k]);
            total++;
            if ({m_phase, m_iso, m_clr, m_done} !== {e, e != 0, e == 2, k == 10}) begin
                bad++;
                $display("FAIL zero_mask k=%0d got ph=%0d done=%b exp ph=%0d done=%b",
                         k, m_phase, m_done, e, k == 10);
            end
            ack = 4'(k * 5);
            tick();
        end
        total++;
        if ({m_err, m_echan, m_busy} !== 6'b0) begin
            bad++; $display("FAIL zero_mask_tail got=%b exp 0", {m_err, m_echan, m_busy});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_late_ack();
        test_mask();
        test_timeout();
        test_back_to_back();
        test_reset_abort();
        test_zero_mask();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clear_seq_ctrl.md
# clear_seq_ctrl

Single-clock, parametrised clear sequencer that walks `NumChannels` downstream agents through the IDLE → ISOLATE → CLEAR → POST_CLEAR → IDLE phase sequence. Each phase waits for a per-channel acknowledge handshake, honours a minimum hold time, and optionally enforces a timeout. It sits on the controlling side of a clear domain, driving the isolation and clear strobes that the CDC clear synchronisers and the attached subsystems consume. It adds several capabilities: an arbitrary channel count, per-sequence channel masking, minimum phase hold, timeout with error capture, and queuing of one pending request.

## Interface
- `NumChannels`, 4: number of acknowledging agents, 1..32.
- `MinHoldCycles`, 2: minimum number of cycles spent in each non-IDLE phase; must be ≥1.
- `TimeoutCycles`, 0: maximum cycles per phase before a forced advance; 0 disables the timeout, otherwise it must be > `MinHoldCycles`.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `clear_req_i`  in  1  single-cycle clear request.
- `chan_en_i`  in  NumChannels  channel participation mask, latched at sequence start.
- `ack_i`  in  NumChannels  per-channel single-cycle acknowledge for the current phase.
- `err_clr_i`  in  1  clears `err_o` and `err_chan_o`.
- `phase_o`  out  2  current phase, `clear_seq_phase_e`.
- `isolate_o`  out  1  high in ISOLATE, CLEAR and POST_CLEAR.
- `clear_o`  out  1  high in CLEAR only.
- `busy_o`  out  1  high when phase ≠ IDLE or a request is pending.
- `done_o`  out  1  one-cycle pulse on the first IDLE cycle after POST_CLEAR.
- `err_o`  out  1  sticky timeout flag.
- `err_chan_o`  out  NumChannels  sticky OR of the channels missing at each timeout.

## Operation
- State registers:
  - `phase_q`
  - `mask_q`
  - `ack_seen_q` (NumChannels)
  - `cnt_q` (width `$clog2(max(MinHoldCycles, TimeoutCycles)+1)`)
  - `pending_q`
  - `done_q`
  - `err_q`
  - `err_chan_q`
- Request acceptance:
  - In IDLE, `clear_req_i` or `pending_q` causes the next phase to be ISOLATE.
  - On acceptance, `mask_q` is loaded from `chan_en_i` and `pending_q` is cleared.
  - In any other phase, `clear_req_i` sets `pending_q`. Further requests merge into the same pending request (at most one queued).
- `all_acked = &(ack_seen_q | ack_i | ~mask_q)`. Current-cycle acks count toward this.
- Advance condition (non-IDLE phases): `cnt_q ≥ MinHoldCycles-1` and `all_acked`.
- Timeout:
  - Triggers when `TimeoutCycles≠0`, `cnt_q == TimeoutCycles-1`, and `!all_acked`.
  - The phase advances anyway.
  - `err_q` is set.
  - `err_chan_q |= mask_q & ~(ack_seen_q | ack_i)`.
- On every phase transition, `cnt_q` and `ack_seen_q` return to 0. Otherwise `cnt_q` saturates-increments and `ack_seen_q |= ack_i & mask_q`.
- Acks received in IDLE or on masked channels are ignored.
- Transition order: ISOLATE → CLEAR → POST_CLEAR → IDLE. `done_q` is set on the POST_CLEAR → IDLE edge.
- Error clearing: `err_clr_i` clears `err_q` and `err_chan_q`. A timeout in the same cycle wins.
- An all-zero mask means every phase lasts exactly `MinHoldCycles`.
- Reset values:
  - `phase_o` = IDLE.
  - All other outputs 0.
  - Pending request discarded.
  - Asserting reset mid-sequence aborts immediately, with no POST_CLEAR and no `done_o`.

## Timing
- Request at edge n (IDLE) → `phase_o` = ISOLATE from cycle n+1. All outputs are registered.
- With `MinHoldCycles=2` and all acks present on the entry cycle: each phase lasts 2 cycles. The full sequence is 6 cycles, and `done_o` rises at cycle n+7.
- Phase duration = max(`MinHoldCycles`, last-ack cycle+1), capped at `TimeoutCycles`.
- A pending request spends exactly one IDLE cycle (with `done_o`=1) and then re-enters ISOLATE.
- `clear_o` and `isolate_o` change on the same edge as `phase_o`, with no glitch between ISOLATE and CLEAR.

## Structure
- Reuse `clear_seq_phase_e` from `cdc_clear_sync_pkg`.
- Add to that package:
  - `clear_seq_is_isolated(phase)` function.
  - `ClearSeqMaxChannels = 32` constant.
- Parameter assertions (elaboration-time):
  - `MinHoldCycles ≥ 1`.
  - `TimeoutCycles == 0 || TimeoutCycles > MinHoldCycles`.
  - `NumChannels ≤ ClearSeqMaxChannels`.
- No sub-module. The counter is inline, because it must reset on phase change and saturate.

## Test plan
- NumChannels=4, MinHold=2, mask 4'hF, all acks held high: `clear_req_i` at cycle 0 → phases ISOLATE 1–2, CLEAR 3–4, POST_CLEAR 5–6; `done_o` at cycle 7; `err_o`=0.
- Ch2 acks ISOLATE at entry+5 only → ISOLATE lasts 6 cycles; ack from ch2 in IDLE beforehand is ignored.
- Mask 4'b1011, ch2 never acks → normal 6-cycle sequence; ch3 silent with TimeoutCycles=8 → each phase lasts 8 cycles; `err_o`=1 and `err_chan_o`=4'b1000 after the first timeout; `err_clr_i` clears both.
- Two `clear_req_i` pulses during CLEAR → one `done_o`, one IDLE cycle, second sequence starts; exactly two `done_o` pulses total.
- `rst_ni` low during CLEAR → `phase_o`=IDLE, `clear_o`/`isolate_o`/`busy_o`=0 immediately; no `done_o` after release.
- Mask 0, MinHold=3 → each phase 3 cycles regardless of `ack_i`.
